// File: rtl/fp16_to_q88_buffer.sv
// binary16 -> signed Q8.8 converter with saturation,
// feeding a show-ahead FIFO with an AXI-Stream master side.
module fp16_to_q88_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  input  logic [15:0]              s_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [15:0]              m_axis_tdata,
  output logic [$clog2(DEPTH):0]   fill_level,
  input  logic                     clr_status,
  output logic                     overflow,
  output logic                     nan_seen,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_nan;
  logic [7:0]    r_drop;

  logic          w_sign;
  logic [4:0]    w_exp;
  logic [9:0]    w_man;
  logic [23:0]   w_sig;
  logic [23:0]   w_mag;
  logic [4:0]    w_lsh;
  logic [4:0]    w_rsh;
  logic          w_zero;
  logic          w_inf;
  logic          w_nan;
  logic          w_pos;
  logic          w_neg;
  logic [15:0]   w_q88;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic          w_drop;

  assign w_sign = s_axis_tdata[15];
  assign w_exp  = s_axis_tdata[14:10];
  assign w_man  = s_axis_tdata[9:0];

  // 24 bits hold 2047 << 13 without wrapping
  assign w_sig  = {13'd0, 1'b1, w_man};
  assign w_lsh  = w_exp - 5'd17;
  assign w_rsh  = 5'd17 - w_exp;
  assign w_mag  = (w_exp >= 5'd17) ? (w_sig << w_lsh)
                                   : (w_sig >> w_rsh);

  assign w_zero = (w_exp == 5'd0);
  assign w_inf  = (w_exp == 5'd31) && (w_man == 10'd0);
  assign w_nan  = (w_exp == 5'd31) && (w_man != 10'd0);
  assign w_pos  = !w_zero && (w_exp != 5'd31) && !w_sign;
  assign w_neg  = !w_zero && (w_exp != 5'd31) && w_sign;

  // Class-based selection of the saturated Q8.8 result
  always_comb begin
    w_q88 = '0;
    unique case (1'b1)
      w_zero: w_q88 = '0;
      w_inf:  w_q88 = w_sign ? 16'h8000 : 16'h7FFF;
      w_nan:  w_q88 = '0;
      w_pos:  w_q88 = (w_mag > 24'd32767) ? 16'h7FFF
                                          : w_mag[15:0];
      w_neg:  w_q88 = (w_mag >= 24'd32768) ? 16'h8000
                                           : (~w_mag[15:0] + 16'd1);
      default: w_q88 = '0;
    endcase
  end

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_rd   = m_axis_tvalid && m_axis_tready;
  assign w_wr   = s_axis_tvalid && (!w_full || w_rd);
  assign w_drop = s_axis_tvalid && w_full && !w_rd;

  assign m_axis_tvalid = (r_cnt != '0);
  assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd] : 16'h0000;
  assign fill_level    = r_cnt;
  assign overflow      = r_ovf;
  assign nan_seen      = r_nan;
  assign drop_count    = r_drop;

  // Storage array; stale entries are masked by the valid gate
  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[r_wr] <= w_q88;
  end

  // Pointers and occupancy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_rd) r_rd <= r_rd + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky status; a clear wins over a same-cycle event
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf  <= 1'b0;
      r_nan  <= 1'b0;
      r_drop <= '0;
    end else if (clr_status) begin
      r_ovf  <= 1'b0;
      r_nan  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
      if (s_axis_tvalid && w_nan) r_nan <= 1'b1;
    end
  end

endmodule
